// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S frame constants and frame assembly helper
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int CH_BITS    = 16;
  localparam int PAD_BITS   = SLOT_BITS - CH_BITS;
  localparam int CNT_BITS   = $clog2(FRAME_BITS);

  // {L, pad, R, pad}: left MSB lands at the top of the shifter.
  function automatic logic [FRAME_BITS-1:0] frame_pack(input logic [2*CH_BITS-1:0] s);
    return {s[2*CH_BITS-1:CH_BITS], {PAD_BITS{1'b0}}, s[CH_BITS-1:0], {PAD_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - BCLK divider with same-cycle fall/rise event strobes
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic bclk_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          tc;

  assign tc = (div_cnt_q == CW'(BCLK_DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q + CW'(1);
    bclk_d    = bclk_q;
    if (tc) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  // Strobes flag the edge on which bclk is about to toggle.
  assign fall_o = tc && bclk_q;
  assign rise_o = tc && !bclk_q;
  assign bclk_o = bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - stereo Philips I2S transmitter; I2S_TX_HOLD_LAST_EN repeats last sample on underrun
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] sample_i,
  output logic        ready,
  output logic        valid,
  output logic        underrun,
  output logic        overrun,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata
);

  logic                  bclk_fall;
  logic                  frame_load;
  logic [FRAME_BITS-1:0] fallback;

  logic [CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shifter_q, shifter_d;
  logic [31:0]           hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  underrun_q, underrun_d;
  logic                  overrun_q, overrun_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk    (clk),
    .rst    (rst),
    .bclk_o (bclk),
    .fall_o (bclk_fall),
    .rise_o ()
  );

  assign frame_load = bclk_fall && (bit_cnt_q == CNT_BITS'(FRAME_BITS - 1));

`ifdef I2S_TX_HOLD_LAST_EN
  logic [31:0] last_q;

  always_ff @(posedge clk) begin
    if (rst)                             last_q <= '0;
    else if (frame_load && hold_full_q)  last_q <= hold_q;
  end

  assign fallback = frame_pack(last_q);
`else
  assign fallback = '0;
`endif

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shifter_d   = shifter_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    valid_d     = 1'b0;
    underrun_d  = 1'b0;
    overrun_d   = en && !ready_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;

    if (bclk_fall) begin
      bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
      lrclk_d   = bit_cnt_d[CNT_BITS-1];
      if (frame_load) begin
        sdata_d = 1'b0;
        if (hold_full_q) begin
          shifter_d   = frame_pack(hold_q);
          hold_full_d = 1'b0;
          valid_d     = 1'b1;
        end else begin
          shifter_d  = fallback;
          underrun_d = 1'b1;
        end
      end else begin
        sdata_d   = shifter_q[FRAME_BITS-1];
        shifter_d = {shifter_q[FRAME_BITS-2:0], 1'b0};
      end
    end

    // Accept after the load so a same-cycle en fills the hold for the next frame.
    if (en && ready_q) begin
      hold_d      = sample_i;
      hold_full_d = 1'b1;
    end

    ready_d = !hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= CNT_BITS'(FRAME_BITS - 1);
      shifter_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      lrclk_q     <= 1'b1;
      sdata_q     <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shifter_q   <= shifter_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
    end
  end

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter: the final sink stage of the audio sample pipeline, directly downstream of the delay/buffer stages. It accepts one packed 32-bit stereo sample per en/ready handshake into a one-deep holding register. It serialises each sample as a standard Philips I2S frame (64 BCLK, 32-bit slots, 16-bit data, MSB first, one-BCLK delay) to the DAC, with BCLK and LRCLK generated from the 100 MHz bus clock.

## Interface
- BCLK_DIV, 16: clk cycles per BCLK half-period; legal ≥ 2. Default gives 3.125 MHz BCLK and a 48.83 kHz frame rate.
- clk  in  1  100 MHz bus clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  sample_i valid strobe; accepted only when ready is high
- sample_i  in  32  [31:16] left, [15:0] right; signed two's complement
- ready  out  1  holding register empty; an en in this cycle is accepted
- valid  out  1  one-cycle pulse when a held sample is launched into a frame
- underrun  out  1  one-cycle pulse when a frame starts with the holding register empty
- overrun  out  1  one-cycle pulse when en arrives while ready is low; that sample is dropped
- bclk  out  1  I2S bit clock
- lrclk  out  1  I2S word select; 0 = left, 1 = right
- sdata  out  1  I2S serial data

## Operation
- All outputs are registered. Reset values: bclk=0, lrclk=1, sdata=0, ready=0, valid=0, underrun=0, overrun=0. Internal reset values: div_cnt=0, bit_cnt=63, hold_full=0, shifter=0.
- ready = !hold_full, registered. ready rises one cycle after rst deasserts.
- Accept: en && ready → hold ← sample_i, hold_full ← 1.
- Reject: en && !ready → sample discarded, overrun pulses the next cycle, hold unchanged.
- Divider: div_cnt counts 0..BCLK_DIV-1. At terminal count, bclk toggles and div_cnt wraps to 0.
- Every falling-edge event (bclk 1→0), bit_cnt increments mod 64:
  - lrclk ← bit_cnt_new[5].
  - When bit_cnt_new==0, a frame load occurs.
  - Otherwise sdata ← shifter[63] and the shifter shifts left one bit, zero-filled.
- Frame load, if hold_full:
  - shifter ← {L, 16'h0, R, 16'h0}.
  - hold_full ← 0.
  - valid pulses.
- Frame load, if !hold_full:
  - underrun pulses and the shifter loads the fallback frame (see Configuration).
  - At the load event, sdata ← 0, which is the last padding bit of the previous frame.
- Resulting bit positions within a frame:
  - L MSB at bit_cnt 1, L LSB at bit_cnt 16, zeros at 17..32.
  - R MSB at bit_cnt 33, R LSB at 48, zeros at 49..63.
- Simultaneous en and frame load, hold empty: the load sees the hold as empty (underrun), and en is captured for the next frame.
- Simultaneous en and frame load, hold full: en is rejected (overrun), because ready was low. ready rises the cycle after the load.
- rst mid-frame: everything returns to reset values the next cycle and the partial frame is abandoned. The DAC sees lrclk high and bclk low until restart.

## Timing
- First frame load happens on the clk edge 2·BCLK_DIV cycles after rst deassertion: bclk rises at BCLK_DIV, falls at 2·BCLK_DIV.
- Frame period is 128·BCLK_DIV clk cycles (2048 at default).
- bclk, lrclk, sdata, valid and underrun update on the same clk edge. sdata/lrclk change only on bclk falling edges, so they are stable for a full BCLK high phase.
- An accepted sample reaches sdata at most one frame period plus 2·BCLK_DIV after acceptance.
- Max sustained input rate is one sample per frame. The upstream stage must respect ready.

## Configuration
- Macro I2S_TX_HOLD_LAST_EN.
- Defined: on underrun, the shifter reloads the most recently launched sample (zero after reset), avoiding clicks.
- Undefined: on underrun, the shifter loads all zeros (silence).
- underrun pulses in both cases.

## Structure
- Package i2s_pkg holds the shared constants: FRAME_BITS=64, SLOT_BITS=32, CH_BITS=16, plus the frame-assembly function {L,pad,R,pad}.
- Sub-module i2s_bclk_gen contains the divider. Outputs: bclk, a fall-event strobe, and a rise-event strobe. Parameter: BCLK_DIV.

## Test plan
- Reset release, no input (BCLK_DIV=4):
  - bclk first rises at cycle 4 and falls at 8.
  - underrun pulses at cycle 8.
  - sdata stays 0 and lrclk period = 64 BCLK.
- Single sample 0x8001_7FFE accepted at cycle 2:
  - valid pulses at the first load.
  - Decoded left = 0x8001, right = 0x7FFE, MSB one BCLK after each lrclk edge, zero padding after.
- Back-to-back en for 3 cycles:
  - First sample accepted, ready low, overrun pulses twice.
  - Only the first sample appears on sdata.
- en in the same cycle as the frame load with hold empty: underrun pulses, and the sample appears in the following frame.
- Underrun after sample 0x1234_5678:
  - With I2S_TX_HOLD_LAST_EN defined, the next frame repeats 0x1234/0x5678.
  - Without it, the next frame is all zeros.
- rst asserted at bit_cnt 20: the next cycle shows bclk=0, lrclk=1, sdata=0, ready=0, then a normal restart.
